// File: rtl/multicycle_pkg.sv
// Shared types and helpers for the multi-cycle control sequencer:
// FSM state encoding, opcode classes and immediate sign extension.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_RD_A,
      S_RD_B,
      S_EXEC,
      S_WAIT,
      S_WB,
      S_RETIRE,
      S_HALTED
   } state_t;

   typedef enum logic [1:0] {
      C_HALT,
      C_NOP,
      C_RR,
      C_RI
   } op_class_t;

   typedef struct packed {
      op_class_t cls;
      logic      is_cmp;
   } op_dec_t;

   localparam logic [3:0] OP_HALT   = 4'h0;
   localparam logic [3:0] OP_CMP_RR = 4'h7;
   localparam logic [3:0] OP_CMP_RI = 4'hF;

   function automatic op_dec_t classify(input logic [3:0] op);
      op_dec_t d;
      d.is_cmp = (op == OP_CMP_RR) || (op == OP_CMP_RI);
      case (op)
         OP_HALT:                                   d.cls = C_HALT;
         4'h1, 4'h2, 4'h3:                          d.cls = C_NOP;
         4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA:        d.cls = C_RR;
         default:                                   d.cls = C_RI;
      endcase
      return d;
   endfunction

   // Sign-extends the low w bits of v to 64 bits; callers truncate to their width.
   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      logic [63:0] mask;
      logic [63:0] sign;
      mask = ~64'd0 << w;
      sign = (v >> (w - 1)) & 64'd1;
      return (sign != 64'd0) ? (v | mask) : (v & ~mask);
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: HALT / NOP / register-register /
// register-immediate, plus whether the opcode is a compare.
module mc_decode
   import multicycle_pkg::*;
(
   input  logic [3:0] i_op,
   output logic [1:0] o_cls,
   output logic       o_is_cmp
);

   op_dec_t w_dec;

   assign w_dec    = classify(i_op);
   assign o_cls    = w_dec.cls;
   assign o_is_cmp = w_dec.is_cmp;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetch, decode, register reads, ALU
// start/done handshake, writeback and PC advance, with HALT/resume.
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int PC_W     = 16,
   parameter int CNT_W    = 16,
   localparam int RIDX_W  = $clog2(NUM_REGS),
   localparam int INSTR_W = 4 + 2 * RIDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               instr_req,
   output logic [PC_W-1:0]    instr_addr,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_data,
   output logic [RIDX_W-1:0]  rf_raddr,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               rf_we,
   output logic [RIDX_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic               alu_start,
   output logic [3:0]         alu_op,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic               alu_done,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic [1:0]         alu_flags,
   output logic [1:0]         flags,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   retired,
   output logic [3:0]         dbg_state
);

   // Handshakes: instr_data is taken on any cycle where instr_req and
   // instr_valid are both high; alu_done is only honoured in S_WAIT.
   state_t               r_state;
   state_t               w_state_nxt;
   logic [PC_W-1:0]      r_pc;
   logic [CNT_W-1:0]     r_retired;
   logic [1:0]           r_flags;
   logic [INSTR_W-1:0]   r_ir;
   logic [DATA_W-1:0]    r_a;
   logic [DATA_W-1:0]    r_b;
   logic [DATA_W-1:0]    r_result;

   logic [3:0]           w_op;
   logic [RIDX_W-1:0]    w_rd;
   logic [RIDX_W-1:0]    w_rs;
   logic [DATA_W-1:0]    w_imm;
   logic [1:0]           w_cls;
   logic                 w_is_cmp;
   logic                 w_advance;

   assign w_op  = r_ir[INSTR_W-1 -: 4];
   assign w_rd  = r_ir[2*RIDX_W-1 -: RIDX_W];
   assign w_rs  = r_ir[RIDX_W-1:0];
   assign w_imm = DATA_W'(sext(64'(w_rs), RIDX_W));

   mc_decode u_decode (
      .i_op     (w_op),
      .o_cls    (w_cls),
      .o_is_cmp (w_is_cmp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      instr_req   = 1'b0;
      rf_raddr    = '0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      alu_start   = 1'b0;
      unique case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_FETCH;
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (w_cls == C_HALT)     w_state_nxt = S_HALTED;
            else if (w_cls == C_NOP) w_state_nxt = S_FETCH;
            else begin
               rf_raddr    = w_rd;
               w_state_nxt = S_RD_A;
            end
         end
         S_RD_A: begin
            if (w_cls == C_RR) begin
               rf_raddr    = w_rs;
               w_state_nxt = S_RD_B;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_RD_B:   w_state_nxt = S_EXEC;
         S_EXEC: begin
            alu_start   = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT:   if (alu_done) w_state_nxt = w_is_cmp ? S_RETIRE : S_WB;
         S_WB: begin
            rf_we       = 1'b1;
            rf_waddr    = w_rd;
            rf_wdata    = r_result;
            w_state_nxt = S_RETIRE;
         end
         S_RETIRE: w_state_nxt = S_FETCH;
         S_HALTED: if (start) w_state_nxt = S_FETCH;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // HALT and NOP complete in DECODE; everything else completes in RETIRE.
   assign w_advance = (r_state == S_RETIRE) ||
                      ((r_state == S_DECODE) && ((w_cls == C_HALT) || (w_cls == C_NOP)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc      <= '0;
         r_retired <= '0;
         r_flags   <= '0;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
      end else begin
         if ((r_state == S_FETCH) && instr_valid) r_ir <= instr_data;
         if (w_advance) begin
            r_pc      <= r_pc + PC_W'(1);
            r_retired <= r_retired + CNT_W'(1);
         end
         if (r_state == S_RD_A) begin
            r_a <= rf_rdata;
            if (w_cls != C_RR) r_b <= w_imm;
         end
         if (r_state == S_RD_B) r_b <= rf_rdata;
         if ((r_state == S_WAIT) && alu_done) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
         end
      end
   end

   assign instr_addr = r_pc;
   assign alu_op     = w_op;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign flags      = r_flags;
   assign busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted     = (r_state == S_HALTED);
   assign retired    = r_retired;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction memory, register file and ALU
// responders, an instruction-level reference model and a per-cycle scoreboard.
module tb_multicycle_ctrl;

   typedef struct {
      logic [3:0]  addr;
      int          lat;
      logic [1:0]  flg;
      logic [15:0] ret;
   } fetch_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        instr_req;
   logic [3:0]  instr_addr;
   logic        instr_valid;
   logic [7:0]  instr_data;
   logic [1:0]  rf_raddr;
   logic [7:0]  rf_rdata;
   logic        rf_we;
   logic [1:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        alu_start;
   logic [3:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_done;
   logic [7:0]  alu_result;
   logic [1:0]  alu_flags;
   logic [1:0]  flags;
   logic        busy;
   logic        halted;
   logic [15:0] retired;
   logic [3:0]  dbg_state;

   logic [7:0]  imem [16];
   logic [7:0]  rf [4];
   logic [7:0]  m_regs [4];
   logic [1:0]  m_flags;
   logic [15:0] m_retired;
   logic        load_en;
   logic [1:0]  load_idx;
   logic [7:0]  load_val;
   int          alu_lat;
   int          fetch_stall;

   fetch_t      exp_fetch_q[$];
   logic [19:0] exp_alu_q[$];
   logic [9:0]  exp_wr_q[$];
   int          lat_hist[$];
   logic [7:0]  alu_b_hist[$];
   int          last_lat;
   logic [19:0] last_alu;
   int          n_chk;
   int          n_fail;

   multicycle_ctrl #(.DATA_W(8), .NUM_REGS(4), .PC_W(4), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst_n),
      .start       (start),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .alu_start   (alu_start),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .flags       (flags),
      .busy        (busy),
      .halted      (halted),
      .retired     (retired),
      .dbg_state   (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Environment ALU: {flags, result}; flags = {a==b, a<b}.
   function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (op)
         4'h4, 4'h9, 4'hC:        r = a + b;
         4'h5, 4'h7, 4'hD, 4'hF:  r = a - b;
         4'h6, 4'hE:              r = a & b;
         4'h8:                    r = a | b;
         default:                 r = a ^ b;
      endcase
      return {(a == b), (a < b), r};
   endfunction

   // Register file with one-cycle read latency, plus a bench preload port.
   always @(posedge clk) begin
      if (load_en)    rf[load_idx] <= load_val;
      else if (rf_we) rf[rf_waddr] <= rf_wdata;
      rf_rdata <= rf[rf_raddr];
   end

   // Instruction memory: valid after fetch_stall cycles of an active request.
   initial begin : fetch_drv
      int rq;
      rq = 0;
      instr_valid = 1'b0;
      instr_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n || !instr_req) begin
            instr_valid = 1'b0;
            instr_data  = 8'h00;
            rq = 0;
         end else begin
            instr_valid = (rq >= fetch_stall);
            instr_data  = instr_valid ? imem[instr_addr] : 8'h00;
            rq++;
         end
      end
   end

   // ALU responder: done alu_lat cycles after the start pulse.
   initial begin : alu_drv
      int cnt;
      bit pend;
      logic [9:0] res;
      cnt = 0;
      pend = 1'b0;
      res = '0;
      alu_done = 1'b0;
      alu_result = 8'h00;
      alu_flags = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            alu_done = 1'b0;
            pend = 1'b0;
         end else begin
            alu_done = 1'b0;
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  alu_done = 1'b1;
                  {alu_flags, alu_result} = res;
                  pend = 1'b0;
               end
            end
            if (alu_start) begin
               pend = 1'b1;
               cnt = alu_lat;
               res = alu_fn(alu_op, alu_a, alu_b);
            end
         end
      end
   end

   // Instruction-level model: walks the program from pc0 up to and including HALT.
   task automatic model_run(input logic [3:0] pc0);
      logic [3:0] pc;
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] a;
      logic [7:0] b;
      logic [9:0] r;
      bit rr;
      bit cmp;
      bit stop;
      int lat;
      fetch_t e;
      pc = pc0;
      stop = 1'b0;
      while (!stop) begin
         op = imem[pc][7:4];
         rd = imem[pc][3:2];
         rs = imem[pc][1:0];
         e.addr = pc;
         e.flg  = m_flags;
         e.ret  = m_retired;
         if (op == 4'h0) begin
            lat = 0;
            stop = 1'b1;
         end else if (op <= 4'h3) begin
            lat = 1;
         end else begin
            rr  = (op <= 4'h8) || (op == 4'hA);
            cmp = (op == 4'h7) || (op == 4'hF);
            lat = (rr ? 7 : 6) - (cmp ? 1 : 0) + alu_lat - 1;
            a = m_regs[rd];
            b = rr ? m_regs[rs] : {{6{rs[1]}}, rs};
            exp_alu_q.push_back({op, a, b});
            r = alu_fn(op, a, b);
            m_flags = r[9:8];
            if (!cmp) begin
               exp_wr_q.push_back({rd, r[7:0]});
               m_regs[rd] = r[7:0];
            end
         end
         e.lat = lat;
         exp_fetch_q.push_back(e);
         pc = pc + 4'd1;
         m_retired = m_retired + 16'd1;
      end
   endtask

   // Scoreboard: checks every cycle against the model queues and handshake rules.
   initial begin : compare
      int idle_cnt;
      int prev_lat;
      int req_run;
      bit alu_wait;
      bit prev_start;
      logic [7:0] held_a;
      logic [7:0] held_b;
      logic [19:0] ea;
      logic [9:0] ew;
      fetch_t ef;
      idle_cnt = 0;
      prev_lat = 0;
      req_run = 0;
      alu_wait = 1'b0;
      prev_start = 1'b0;
      held_a = '0;
      held_b = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            idle_cnt = 0;
            prev_lat = 0;
            req_run = 0;
            alu_wait = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (halted) chk("halted_quiet", {30'd0, instr_req, busy}, 0);
            if (instr_req) chk("req_implies_busy", busy, 1);
            if (alu_start) begin
               chk("alu_start_pulse", prev_start, 0);
               if (exp_alu_q.size() == 0) chk("alu_unexpected", 1, 0);
               else begin
                  ea = exp_alu_q.pop_front();
                  chk("alu_op", alu_op, ea[19:16]);
                  chk("alu_a", alu_a, ea[15:8]);
                  chk("alu_b", alu_b, ea[7:0]);
               end
               held_a = alu_a;
               held_b = alu_b;
               last_alu = {alu_op, alu_a, alu_b};
               alu_b_hist.push_back(alu_b);
               alu_wait = 1'b1;
            end else if (alu_wait) begin
               chk("alu_a_stable", alu_a, held_a);
               chk("alu_b_stable", alu_b, held_b);
               chk("busy_in_wait", busy, 1);
               if (alu_done) alu_wait = 1'b0;
            end
            prev_start = alu_start;
            if (rf_we) begin
               if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
               else begin
                  ew = exp_wr_q.pop_front();
                  chk("wr_addr", rf_waddr, ew[9:8]);
                  chk("wr_data", rf_wdata, ew[7:0]);
               end
            end
            if (instr_req) begin
               req_run++;
               if (instr_valid) begin
                  chk("req_held_through_stall", req_run, fetch_stall + 1);
                  if (prev_lat != 0) begin
                     chk("latency", idle_cnt, prev_lat);
                     last_lat = idle_cnt;
                     lat_hist.push_back(idle_cnt);
                  end
                  if (exp_fetch_q.size() == 0) begin
                     chk("fetch_unexpected", 1, 0);
                     prev_lat = 0;
                  end else begin
                     ef = exp_fetch_q.pop_front();
                     chk("fetch_addr", instr_addr, ef.addr);
                     chk("flags_at_fetch", flags, ef.flg);
                     chk("retired_at_fetch", retired, ef.ret);
                     prev_lat = ef.lat;
                  end
                  idle_cnt = 0;
               end
            end else begin
               req_run = 0;
               idle_cnt++;
            end
         end
      end
   end

   task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
      @(negedge clk);
      load_en  = 1'b1;
      load_idx = idx;
      load_val = val;
      @(negedge clk);
      load_en  = 1'b0;
      m_regs[idx] = val;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int max_cyc);
      int n;
      n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      #2;
      chk("halt_reached", halted, 1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] saved [4];
      int n;
      n_chk = 0;
      n_fail = 0;
      last_lat = 0;
      last_alu = '0;
      rst_n = 1'b0;
      start = 1'b0;
      load_en = 1'b0;
      load_idx = 2'd0;
      load_val = 8'd0;
      alu_lat = 1;
      fetch_stall = 0;
      m_flags = 2'b00;
      m_retired = 16'd0;
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
      imem[0]  = 8'h41;
      imem[1]  = 8'h00;
      imem[2]  = 8'hC7;
      imem[3]  = 8'hC6;
      imem[4]  = 8'hC5;
      imem[5]  = 8'h00;
      imem[6]  = 8'h71;
      imem[7]  = 8'h00;
      imem[8]  = 8'h4D;
      imem[9]  = 8'h00;
      imem[10] = 8'h10;
      imem[11] = 8'h25;
      imem[12] = 8'h3A;
      imem[13] = 8'h1F;
      imem[14] = 8'h20;
      imem[15] = 8'h12;

      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_instr_req", instr_req, 0);
      chk("rst_pc", instr_addr, 0);
      chk("rst_retired", retired, 0);
      chk("rst_flags", flags, 0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_state_idle", dbg_state, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      load_reg(2'd0, 8'd3);
      load_reg(2'd1, 8'd5);
      load_reg(2'd2, 8'd0);
      load_reg(2'd3, 8'd0);
      chk("idle_no_start", {30'd0, busy, instr_req}, 0);

      // RR add r0 = 3 + 5, then HALT
      model_run(4'd0);
      pulse_start();
      wait_halt(100);
      chk("rr_latency", last_lat, 7);
      chk("rr_alu_op_a_b", last_alu, 20'h40305);
      chk("rr_rf_r0", rf[0], 8'd8);
      chk("rr_retired", retired, 2);
      chk("rr_pc", instr_addr, 2);
      chk("rr_flags", flags, 2'b01);

      // RI sign extension, HALT at pc 5
      alu_b_hist.delete();
      model_run(4'd2);
      pulse_start();
      wait_halt(100);
      chk("ri_imm_3", (alu_b_hist.size() > 0) ? alu_b_hist[0] : 8'hxx, 8'hFF);
      chk("ri_imm_2", (alu_b_hist.size() > 1) ? alu_b_hist[1] : 8'hxx, 8'hFE);
      chk("ri_imm_1", (alu_b_hist.size() > 2) ? alu_b_hist[2] : 8'hxx, 8'h01);
      chk("ri_latency", last_lat, 6);
      chk("halt_pc", instr_addr, 6);
      chk("halt_no_req", instr_req, 0);

      // compare r0 == r1 -> flags 2'b10, no writeback
      load_reg(2'd1, 8'd8);
      model_run(4'd6);
      pulse_start();
      wait_halt(100);
      chk("cmp_flags", flags, 2'b10);
      chk("cmp_pc", instr_addr, 8);
      chk("cmp_latency", last_lat, 6);
      chk("cmp_retired", retired, 8);

      // fetch stall of 5 cycles, ALU done withheld 10 extra cycles
      fetch_stall = 5;
      alu_lat = 11;
      model_run(4'd8);
      pulse_start();
      wait_halt(200);
      chk("stall_latency", last_lat, 17);
      fetch_stall = 0;
      alu_lat = 1;

      // NOP run through pc 15, wrapping to 0
      lat_hist.delete();
      model_run(4'd10);
      pulse_start();
      wait_halt(200);
      chk("nop_latency", (lat_hist.size() > 0) ? lat_hist[0] : -1, 1);
      chk("wrap_pc", instr_addr, 2);
      chk("wrap_retired", retired, 18);
      chk("wrap_rr_latency", last_lat, 7);

      // reset in the middle of a long ALU wait
      for (int i = 0; i < 4; i++) saved[i] = m_regs[i];
      alu_lat = 20;
      model_run(4'd2);
      pulse_start();
      n = 0;
      while (!alu_start && n < 50) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("alu_start_seen", alu_start, 1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rf_we", rf_we, 0);
      chk("mid_rst_alu_start", alu_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pc", instr_addr, 0);
      chk("mid_rst_retired", retired, 0);
      chk("mid_rst_flags", flags, 0);
      exp_fetch_q.delete();
      exp_alu_q.delete();
      exp_wr_q.delete();
      for (int i = 0; i < 4; i++) m_regs[i] = saved[i];
      m_flags = 2'b00;
      m_retired = 16'd0;
      alu_lat = 1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         #2;
         chk("post_rst_idle", {30'd0, busy, instr_req}, 0);
      end

      // normal operation resumes from pc 0
      model_run(4'd0);
      pulse_start();
      wait_halt(100);
      chk("restart_pc", instr_addr, 2);
      chk("restart_retired", retired, 2);

      repeat (2) @(negedge clk);
      chk("fetch_q_drained", exp_fetch_q.size(), 0);
      chk("alu_q_drained", exp_alu_q.size(), 0);
      chk("wr_q_drained", exp_wr_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
